// File: rtl/bchecc_gfmult_ds.sv
// Digit-serial GF(2^M) multiplier: a*b, c ^ a*b or a^2 mod f(x), D bits of the
// multiplier per clock (MSB digit first), with valid/ready on both sides.
module bchecc_gfmult_ds #(
  parameter int             M    = 13,
  parameter logic [M-1:0]   POLY = 13'h001B,
  parameter int             D    = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [1:0]   mode_i,
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  input  logic [M-1:0] c_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [M-1:0] s_o,
  output logic         busy_o
);

  localparam int NDIG = (M + D - 1) / D;
  localparam int W    = NDIG * D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [M-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [M-1:0]   c_r;
  logic [M-1:0]   p_r;
  logic [CW-1:0]  cnt_r;
  logic [M-1:0]   s_r;
  logic           out_valid_r;

  logic           accept_s;
  logic           last_s;
  logic [M-1:0]   p_nxt_s;
  logic [W-1:0]   b_load_s;
  logic [M-1:0]   c_load_s;

  // Multiply by x and reduce the single overflow bit back through f(x).
  function automatic logic [M-1:0] gf_mulx(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : {M{1'b0}});
  endfunction

  // Horner step over one digit: returns p*x^D ^ a*dig, reduced after every bit.
  function automatic logic [M-1:0] gf_step(input logic [M-1:0] p,
                                           input logic [M-1:0] a,
                                           input logic [D-1:0] dig);
    logic [M-1:0] r;
    r = p;
    for (int i = D - 1; i >= 0; i--) begin
      r = gf_mulx(r) ^ (dig[i] ? a : {M{1'b0}});
    end
    return r;
  endfunction

  assign in_ready_o  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready_i);
  assign accept_s    = in_valid_i & in_ready_o & ~flush_i;
  assign last_s      = (state_r == ST_CALC) & (cnt_r == {CW{1'b0}});
  assign p_nxt_s     = gf_step(p_r, a_r, b_r[W-1 -: D]);
  assign out_valid_o = out_valid_r;
  assign s_o         = s_r;
  assign busy_o      = (state_r != ST_IDLE);

  // Operand selection at accept: squaring reuses a, accumulate only in mode 01.
  always_comb begin
    b_load_s = {W{1'b0}};
    if (mode_i == 2'b10) begin
      b_load_s[M-1:0] = a_i;
    end else begin
      b_load_s[M-1:0] = b_i;
    end
    if (mode_i == 2'b01) begin
      c_load_s = c_i;
    end else begin
      c_load_s = {M{1'b0}};
    end
  end

  // Next-state logic; flush overrides accept and completion.
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = ST_CALC;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end
        ST_DONE: begin
          if (accept_s) begin
            state_nxt_s = ST_CALC;
          end else if (out_ready_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and digit-serial accumulation.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_r   <= {M{1'b0}};
      b_r   <= {W{1'b0}};
      c_r   <= {M{1'b0}};
      p_r   <= {M{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      a_r   <= a_i;
      b_r   <= b_load_s;
      c_r   <= c_load_s;
      p_r   <= {M{1'b0}};
      cnt_r <= CW'(NDIG - 1);
    end else if ((state_r == ST_CALC) && !flush_i) begin
      p_r   <= p_nxt_s;
      b_r   <= b_r << D;
      cnt_r <= cnt_r - CW'(1);
    end else begin
      p_r   <= p_r;
    end
  end

  // Result register: s_o only changes on completion, so flush and consume keep it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_r <= 1'b0;
      s_r         <= {M{1'b0}};
    end else if (flush_i) begin
      out_valid_r <= 1'b0;
    end else if (last_s) begin
      out_valid_r <= 1'b1;
      s_r         <= p_nxt_s ^ c_r;
    end else if ((state_r == ST_DONE) && out_ready_i) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_bchecc_gfmult_ds.sv
// Directed bench for bchecc_gfmult_ds: four instances (D = 4, 1, 5, 13) of the
// default 13-bit field, table vectors plus handshake, flush and reset sequences.
module tb_bchecc_gfmult_ds;

  localparam int NI = 4;

  function automatic int d_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 5;
      default: return 13;
    endcase
  endfunction

  function automatic int ndig_of(input int k);
    return (13 + d_of(k) - 1) / d_of(k);
  endfunction

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [12:0] a, b, c;
  logic        flush;
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic [12:0] s         [NI];
  logic        busy      [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bchecc_gfmult_ds #(.M(13), .POLY(13'h001B), .D(d_of(g))) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .mode_i      (mode),
      .a_i         (a),
      .b_i         (b),
      .c_i         (c),
      .flush_i     (flush),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .s_o         (s[g]),
      .busy_o      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [12:0] a;
    logic [12:0] b;
    logic [12:0] c;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs [13];

  // Bit-serial reference, one multiplier bit per step.
  function automatic logic [12:0] ref_op(input logic [1:0] m, input logic [12:0] x,
                                         input logic [12:0] y, input logic [12:0] z);
    logic [12:0] bb, r;
    bb = (m == 2'b10) ? x : y;
    r  = 13'h0000;
    for (int i = 12; i >= 0; i--) begin
      r = {r[11:0], 1'b0} ^ (r[12] ? 13'h001B : 13'h0000) ^ (bb[i] ? x : 13'h0000);
    end
    return r ^ ((m == 2'b01) ? z : 13'h0000);
  endfunction

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d (D=%0d): got 0x%0h expected 0x%0h", name, k, d_of(k), act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_and_wait(input int k, input logic [1:0] m, input logic [12:0] x,
                                input logic [12:0] y, input logic [12:0] z, output int lat);
    int cyc;
    cyc = 0;
    while (!in_ready[k] && cyc < 20) begin tick(); cyc++; end
    chk(k, "ready_before_issue", in_ready[k], 1);
    mode = m; a = x; b = y; c = z;
    in_valid[k] = 1'b1;
    tick();
    in_valid[k] = 1'b0;
    mode = 2'($urandom); a = 13'($urandom); b = 13'($urandom); c = 13'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 40) begin tick(); lat++; end
  endtask

  task automatic consume(input int k);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  task automatic do_op(input int k, input vec_t v);
    int lat;
    issue_and_wait(k, v.mode, v.a, v.b, v.c, lat);
    chk(k, "latency", lat, ndig_of(k));
    chk(k, "result", s[k], v.exp);
    consume(k);
    chk(k, "valid_after_consume", out_valid[k], 0);
    chk(k, "s_kept_after_consume", s[k], v.exp);
  endtask

  task automatic back_to_back(input int k);
    logic [1:0]  om [8];
    logic [12:0] oa [8], ob [8], oc [8], oe [8];
    int issued, got, cyc, last;
    logic acc;
    for (int i = 0; i < 8; i++) begin
      om[i] = 2'($urandom); oa[i] = 13'($urandom); ob[i] = 13'($urandom); oc[i] = 13'($urandom);
      oe[i] = ref_op(om[i], oa[i], ob[i], oc[i]);
    end
    issued = 0; got = 0; cyc = 0; last = 0;
    mode = om[0]; a = oa[0]; b = ob[0]; c = oc[0];
    in_valid[k] = 1'b1;
    out_ready[k] = 1'b1;
    while (got < 8 && cyc < 300) begin
      acc = in_ready[k] && in_valid[k];
      tick();
      cyc++;
      if (acc) begin
        issued++;
        if (issued < 8) begin
          mode = om[issued]; a = oa[issued]; b = ob[issued]; c = oc[issued];
        end else begin
          in_valid[k] = 1'b0;
        end
      end
      if (out_valid[k]) begin
        chk(k, "b2b_result", s[k], oe[got]);
        if (got > 0) chk(k, "b2b_period", cyc - last, ndig_of(k) + 1);
        last = cyc;
        got++;
      end
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    chk(k, "b2b_count", got, 8);
    tick();
  endtask

  initial begin
    int lat, seen;
    logic [12:0] s_before;

    vecs[0]  = '{2'b00, 13'h1000, 13'h0002, 13'h0000, 13'h001B};
    vecs[1]  = '{2'b00, 13'h1000, 13'h1000, 13'h0000, 13'h185A};
    vecs[2]  = '{2'b10, 13'h1000, 13'h0777, 13'h0000, 13'h185A};
    vecs[3]  = '{2'b01, 13'h1000, 13'h0002, 13'h0001, 13'h001A};
    vecs[4]  = '{2'b00, 13'h1ABC, 13'h0001, 13'h0000, 13'h1ABC};
    vecs[5]  = '{2'b00, 13'h1ABC, 13'h0000, 13'h0000, 13'h0000};
    vecs[6]  = '{2'b01, 13'h0000, 13'h0005, 13'h0123, 13'h0123};
    vecs[7]  = '{2'b11, 13'h1000, 13'h0002, 13'h0FFF, 13'h001B};
    vecs[8]  = '{2'b00, 13'h0003, 13'h0003, 13'h1FFF, 13'h0005};
    vecs[9]  = '{2'b10, 13'h0003, 13'h1FFF, 13'h0000, 13'h0005};
    vecs[10] = '{2'b00, 13'h1000, 13'h0004, 13'h0000, 13'h0036};
    vecs[11] = '{2'b00, 13'h0001, 13'h1FFF, 13'h0000, 13'h1FFF};
    vecs[12] = '{2'b01, 13'h0002, 13'h0003, 13'h0006, 13'h0000};

    rst_n = 1'b0; flush = 1'b0; mode = 2'b00; a = '0; b = '0; c = '0;
    for (int k = 0; k < NI; k++) begin in_valid[k] = 1'b0; out_ready[k] = 1'b0; end
    repeat (2) tick();
    for (int k = 0; k < NI; k++) begin
      chk(k, "rst_out_valid", out_valid[k], 0);
      chk(k, "rst_s", s[k], 0);
      chk(k, "rst_busy", busy[k], 0);
      chk(k, "rst_in_ready", in_ready[k], 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 13; i++) do_op(k, vecs[i]);
    end

    // Result held while the consumer stalls, even with a new operand set offered.
    issue_and_wait(0, 2'b00, 13'h1ABC, 13'h0001, 13'h0000, lat);
    chk(0, "hold_latency", lat, 4);
    mode = 2'b00; a = 13'h0001; b = 13'h0001; c = 13'h0000;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(0, "hold_s", s[0], 13'h1ABC);
      chk(0, "hold_valid", out_valid[0], 1);
      chk(0, "hold_in_ready", in_ready[0], 0);
      chk(0, "hold_busy", busy[0], 1);
    end
    in_valid[0] = 1'b0;
    consume(0);
    chk(0, "hold_release", out_valid[0], 0);

    for (int k = 0; k < NI; k++) back_to_back(k);

    // Flush two cycles after accept.
    s_before = s[0];
    mode = 2'b00; a = 13'h1000; b = 13'h0002; c = 13'h0000;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    chk(0, "pre_flush_busy", busy[0], 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk(0, "flush_busy", busy[0], 0);
    chk(0, "flush_in_ready", in_ready[0], 1);
    chk(0, "flush_valid", out_valid[0], 0);
    chk(0, "flush_s_kept", s[0], s_before);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid[0]) seen++;
    end
    chk(0, "flush_no_result", seen, 0);

    // Flush beats accept in IDLE.
    in_valid[0] = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid[0] = 1'b0;
    chk(0, "flush_blocks_accept", busy[0], 0);
    do_op(0, vecs[1]);

    // Asynchronous reset mid-calculation.
    mode = 2'b00; a = 13'h1ABC; b = 13'h1234; c = 13'h0000;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk(0, "arst_valid", out_valid[0], 0);
    chk(0, "arst_s", s[0], 0);
    chk(0, "arst_busy", busy[0], 0);
    chk(0, "arst_in_ready", in_ready[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_op(0, vecs[3]);
    do_op(0, '{2'b00, 13'h1ABC, 13'h1234, 13'h0000, ref_op(2'b00, 13'h1ABC, 13'h1234, 13'h0000)});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bchecc_gfmult_ds.md
Name: bchecc_gfmult_ds

Overview:
- Parametrised, digit-serial GF(2^M) multiplier with valid/ready handshakes, for BCH ECC syndrome, key-equation and Chien datapaths that need an area-reduced multiplier.
- Computes a*b mod f(x), c ^ a*b mod f(x), or a^2 mod f(x).
- Processes D bits of the multiplier operand per clock, MSB digit first.
- Defaults reproduce the existing 13-bit field with f(x)=x^13+x^4+x^3+x+1.

Parameters:
- M, 13: field degree and operand/result width.
- POLY, 13'h001B: low M bits of f(x); x^M term implicit.
- D, 4: digit size in bits; 1 <= D <= M.
- NDIG, derived = ceil(M/D): digits per operation (4 at default).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operand set valid.
- in_ready_o  output  1  block can accept operands.
- mode_i  input  2  00 multiply, 01 multiply-accumulate, 10 square, 11 reserved (treated as 00).
- a_i  input  M  multiplicand.
- b_i  input  M  multiplier; ignored in mode 10, where b := a.
- c_i  input  M  accumulate addend; used only in mode 01.
- flush_i  input  1  synchronous abort.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- s_o  output  M  result.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (rst_n_i low, async) sets:
  - state IDLE;
  - out_valid_o=0, s_o=0, busy_o=0;
  - internal A/B/C/P registers and digit counter to 0.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). It is combinational and 1 immediately after reset.
- Accept occurs when in_valid_i & in_ready_o on a rising edge. On accept:
  - latch A=a_i;
  - latch B=b_i, or a_i in mode 10, zero-padded on the left to NDIG*D bits;
  - latch C=c_i if mode 01, else 0;
  - clear P=0, load counter=NDIG-1, go to CALC.
- CALC: each edge, P <= (P*x^D mod f) ^ (A*B_digit mod f), where B_digit is the current top digit. Then shift B left by D and decrement the counter.
  - The reduction of the up to (M+D-1)-bit intermediate is fully combinational inside the cycle.
  - On the edge that processes the last digit (counter==0), s_o <= P_next ^ C, out_valid_o <= 1, state <= DONE.
- Latency: an operation accepted at edge k presents out_valid_o=1 from edge k+NDIG. At default this is 4 cycles.
- DONE: s_o and out_valid_o are held stable while out_ready_i=0.
  - out_ready_i=1 without a new accept: out_valid_o <= 0 and state <= IDLE. s_o keeps its last value.
  - out_ready_i=1 together with a new accept on the same edge: the result is consumed and the new operands are loaded. state <= CALC, out_valid_o <= 0. This gives a throughput of one result per NDIG+1 cycles.
- flush_i=1: returns to IDLE on the next edge from any state, clears out_valid_o, and discards the operation in progress. s_o is unchanged.
  - flush_i has priority over accept and completion on the same edge.
  - While flush_i=1, in_ready_o is still driven per the formula, but the accept is ignored.
- Inputs a_i/b_i/c_i/mode_i are sampled only on accept. Changes afterwards must not affect the result.
- Operands wider than the field are not possible. Zero operand(s) give 0 (mode 01: gives c).
- If M mod D != 0, the top digit holds M mod D real bits and the padding bits are zero. The result must be identical for every D.
- busy_o = 1 in CALC and DONE.

Test Plan:
- Reset, then mode 00, a=13'h1000, b=13'h0002 -> out_valid_o rises exactly 4 cycles after accept, s_o=13'h001B (alpha^13).
- Mode 00, a=13'h1000, b=13'h1000; then mode 10, a=13'h1000 -> s_o=13'h185A both times.
- Mode 01, a=13'h1000, b=13'h0002, c=13'h0001 -> s_o=13'h001A.
- Identity/zero: a=13'h1ABC, b=1 -> 13'h1ABC; b=0 -> 0. Hold out_ready_i=0 for 5 cycles -> s_o and out_valid_o stable, in_ready_o=0.
- Back-to-back: keep in_valid_i and out_ready_i high for 8 operations -> one result every 5 cycles, all values matching a bit-serial reference model. Repeat with D=1, D=5 and D=13 -> identical results, latency 13, 3 and 1 cycles.
- flush_i asserted 2 cycles after accept -> IDLE next cycle, no out_valid_o. An async reset mid-CALC -> all outputs 0 immediately, and the next operation is correct.
